// File: rtl/onehot_key_capture_4_pkg.sv
// Shared types and constants for the one-hot key capture block.
// State encoding and one-hot helper used by the top-level FSM.
package onehot_key_capture_4_pkg;

    localparam int KEY_W               = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        MULTI    = 2'd2,
        WAIT_REL = 2'd3
    } state_e;

    function automatic logic is_onehot(input logic [KEY_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/onehot_key_capture_4_debounce_bit.sv
// One key line: 2-flop synchroniser, stability counter, debounced level.
// deb only follows s after DEBOUNCE_CYCLES consecutive differing cycles.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic deb_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (s2_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/onehot_key_capture_4.sv
// Debounced one-hot key capture feeding the 4:2 encoder D input.
// Multi-key or aborted captures always present 4'b0000 downstream.
module onehot_key_capture_4
    import onehot_key_capture_4_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             clear,
    output logic [KEY_W-1:0] D_out,
    output logic             valid,
    output logic             press_pulse,
    output logic             error
);

    logic [KEY_W-1:0] deb;

    for (genvar i = 0; i < KEY_W; i++) begin : g_deb
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw_i(key_in[i]),
            .deb_o(deb[i])
        );
    end

    state_e           state_q, state_d;
    logic [KEY_W-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             pulse_q, pulse_d;
    logic             error_q, error_d;

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        pulse_d = 1'b0;
        error_d = error_q;
        if (clear) begin
            state_d = WAIT_REL;
            dout_d  = '0;
            valid_d = 1'b0;
            error_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (is_onehot(deb)) begin
                        state_d = HELD;
                        dout_d  = deb;
                        valid_d = 1'b1;
                        pulse_d = 1'b1;
                    end else if (deb != '0) begin
                        state_d = MULTI;
                        error_d = 1'b1;
                    end
                end
                HELD: begin
                    if (deb == '0) begin
                        state_d = IDLE;
                        dout_d  = '0;
                        valid_d = 1'b0;
                    end else if (deb != dout_q) begin
                        state_d = MULTI;
                        dout_d  = '0;
                        valid_d = 1'b0;
                        error_d = 1'b1;
                    end
                end
                // Only a full release leaves MULTI; never straight back to HELD.
                MULTI: begin
                    if (deb == '0) begin
                        state_d = IDLE;
                        error_d = 1'b0;
                    end
                end
                WAIT_REL: begin
                    if (deb == '0) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dout_q  <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            error_q <= error_d;
        end
    end

    assign D_out       = dout_q;
    assign valid       = valid_q;
    assign press_pulse = pulse_q;
    assign error       = error_q;

endmodule

// File: tb/tb_onehot_key_capture_4.sv
// Directed bench for onehot_key_capture_4 (DEBOUNCE_CYCLES=4).
// Inputs change 1ns after a rising edge; outputs sampled there too.
module tb_onehot_key_capture_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_in;
    logic       clear;
    logic [3:0] D_out;
    logic       valid;
    logic       press_pulse;
    logic       error;

    int nvec = 0;
    int nerr = 0;

    onehot_key_capture_4 #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .clear      (clear),
        .D_out      (D_out),
        .valid      (valid),
        .press_pulse(press_pulse),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        key_in = 4'b0000;
        clear  = 1'b0;
        #12;
        nvec++;
        if ({D_out, valid, press_pulse, error} !== 7'b0) begin
            nerr++;
            $display("FAIL reset_outputs got %b want 0000000",
                     {D_out, valid, press_pulse, error});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
        nvec++;
        if ({D_out, valid, error} !== 6'b0) begin
            nerr++;
            $display("FAIL reset_release got %b want 000000", {D_out, valid, error});
        end
    endtask

    task automatic test_single_press;
        key_in = 4'b0010;
        tick(6);
        nvec++;
        if (valid !== 1'b0) begin
            nerr++;
            $display("FAIL press_early_valid got %b want 0", valid);
        end
        tick(1);
        nvec++;
        if ({D_out, valid, press_pulse, error} !== 7'b0010_1_1_0) begin
            nerr++;
            $display("FAIL press_capture got %b want 0010110",
                     {D_out, valid, press_pulse, error});
        end
        tick(1);
        nvec++;
        if ({D_out, valid, press_pulse} !== 6'b0010_1_0) begin
            nerr++;
            $display("FAIL press_pulse_drop got %b want 001010", {D_out, valid, press_pulse});
        end
        key_in = 4'b0000;
        tick(6);
        nvec++;
        if ({D_out, valid} !== 5'b0010_1) begin
            nerr++;
            $display("FAIL release_early got %b want 00101", {D_out, valid});
        end
        tick(1);
        nvec++;
        if ({D_out, valid, error} !== 6'b0) begin
            nerr++;
            $display("FAIL release_done got %b want 000000", {D_out, valid, error});
        end
    endtask

    task automatic test_glitch;
        logic seen;
        seen   = 1'b0;
        key_in = 4'b1000;
        tick(3);
        key_in = 4'b0000;
        repeat (12) begin
            tick(1);
            if (valid || press_pulse || error || D_out != 4'b0) seen = 1'b1;
        end
        nvec++;
        if (seen !== 1'b0) begin
            nerr++;
            $display("FAIL glitch_rejected got %b want 0", seen);
        end
    endtask

    task automatic test_multi_key;
        key_in = 4'b0001;
        tick(8);
        nvec++;
        if ({D_out, valid} !== 5'b0001_1) begin
            nerr++;
            $display("FAIL multi_held got %b want 00011", {D_out, valid});
        end
        key_in = 4'b0101;
        tick(8);
        nvec++;
        if ({D_out, valid, error} !== 6'b0000_0_1) begin
            nerr++;
            $display("FAIL multi_enter got %b want 000001", {D_out, valid, error});
        end
        key_in = 4'b0001;
        tick(8);
        nvec++;
        if ({D_out, valid, error} !== 6'b0000_0_1) begin
            nerr++;
            $display("FAIL multi_sticky got %b want 000001", {D_out, valid, error});
        end
        key_in = 4'b0000;
        tick(8);
        nvec++;
        if ({D_out, valid, error} !== 6'b0) begin
            nerr++;
            $display("FAIL multi_exit got %b want 000000", {D_out, valid, error});
        end
        key_in = 4'b0100;
        tick(8);
        nvec++;
        if ({D_out, valid, error} !== 6'b0100_1_0) begin
            nerr++;
            $display("FAIL multi_idle_recap got %b want 010010", {D_out, valid, error});
        end
        key_in = 4'b0000;
        tick(8);
    endtask

    task automatic test_simultaneous;
        logic seen;
        seen   = 1'b0;
        key_in = 4'b1001;
        repeat (10) begin
            tick(1);
            if (valid || press_pulse) seen = 1'b1;
        end
        nvec++;
        if (seen !== 1'b0) begin
            nerr++;
            $display("FAIL simul_no_valid got %b want 0", seen);
        end
        nvec++;
        if ({D_out, error} !== 5'b0000_1) begin
            nerr++;
            $display("FAIL simul_error got %b want 00001", {D_out, error});
        end
        key_in = 4'b0000;
        tick(8);
        nvec++;
        if (error !== 1'b0) begin
            nerr++;
            $display("FAIL simul_exit got %b want 0", error);
        end
    endtask

    task automatic test_clear;
        logic seen;
        seen   = 1'b0;
        key_in = 4'b1000;
        tick(8);
        nvec++;
        if ({D_out, valid} !== 5'b1000_1) begin
            nerr++;
            $display("FAIL clear_held got %b want 10001", {D_out, valid});
        end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        nvec++;
        if ({D_out, valid, press_pulse, error} !== 7'b0) begin
            nerr++;
            $display("FAIL clear_abort got %b want 0000000",
                     {D_out, valid, press_pulse, error});
        end
        repeat (10) begin
            tick(1);
            if (valid || D_out != 4'b0) seen = 1'b1;
        end
        nvec++;
        if (seen !== 1'b0) begin
            nerr++;
            $display("FAIL clear_no_recap got %b want 0", seen);
        end
        key_in = 4'b0000;
        tick(8);
        key_in = 4'b0010;
        tick(8);
        nvec++;
        if ({D_out, valid} !== 5'b0010_1) begin
            nerr++;
            $display("FAIL clear_recap got %b want 00101", {D_out, valid});
        end
        key_in = 4'b0000;
        tick(8);
    endtask

    task automatic test_reset_mid_held;
        key_in = 4'b0100;
        tick(8);
        nvec++;
        if ({D_out, valid} !== 5'b0100_1) begin
            nerr++;
            $display("FAIL async_pre got %b want 01001", {D_out, valid});
        end
        #1;
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({D_out, valid, error} !== 6'b0) begin
            nerr++;
            $display("FAIL async_reset got %b want 000000", {D_out, valid, error});
        end
        key_in = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_multi_key();
        test_simultaneous();
        test_clear();
        test_reset_mid_held();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
